// File: rtl/ram_clear_port.sv
// Single-port synchronous RAM that zero-fills itself after reset or a clear
// pulse, then serves pipelined reads and single-cycle writes.
module ram_clear_port #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [READ_LAT-1:0] pipe_vld;
  logic [DATA_W-1:0] pipe_data [READ_LAT];
  logic              accept;
  logic              rd_acc;
  logic              wr_acc;

  assign accept = req && ready && !clr;
  assign rd_acc = accept && !we;
  assign wr_acc = accept && we;

  // ready is asserted on the very edge that clears the last word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= INIT;
      clr_cnt <= '0;
      ready   <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (clr) begin
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == LAST_ADDR) begin
              state <= RUN;
              ready <= 1'b1;
            end
          end
        end
        RUN: begin
          if (clr) begin
            state   <= INIT;
            clr_cnt <= '0;
            ready   <= 1'b0;
          end
        end
        default: begin
          state   <= INIT;
          clr_cnt <= '0;
          ready   <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset; the zero-fill pass owns the write port while in INIT
  always_ff @(posedge clk) begin
    if (state == INIT && !clr)
      mem[clr_cnt] <= '0;
    else if (wr_acc)
      mem[addr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld <= '0;
      for (int i = 0; i < READ_LAT; i++)
        pipe_data[i] <= '0;
    end else if (clr) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= rd_acc;
      if (rd_acc)
        pipe_data[0] <= mem[addr];
      // data only advances behind a valid bit so the output stage holds its last read
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        if (pipe_vld[i-1])
          pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

  assign rdata_valid = pipe_vld[READ_LAT-1];
  assign rdata       = pipe_data[READ_LAT-1];

endmodule

// File: tb/tb_ram_clear_port.sv
// Bench for ram_clear_port: directed table, corner sequences and random
// traffic checked against a cycle-level behavioural model of the memory.
module tb_ram_clear_port;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int LAT    = 3;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              clr;
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              rdata_valid;
  logic [DATA_W-1:0] rdata;

  ram_clear_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .clr(clr), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .ready(ready), .rdata_valid(rdata_valid), .rdata(rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              expv;
    logic [DATA_W-1:0] expd;
  } vec_t;

  typedef struct {
    int                due;
    logic [DATA_W-1:0] data;
  } rd_t;

  int nChecks = 0;
  int nFail   = 0;

  // reference model state
  logic [DATA_W-1:0] memM [DEPTH];
  rd_t               pend [$];
  int                cyc;
  int                fill;
  logic              readyM;
  logic              expV;
  logic [DATA_W-1:0] lastD;

  vec_t tbl [8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic modelEdge();
    cyc++;
    if (clr) begin
      fill   = 0;
      readyM = 1'b0;
      pend.delete();
    end else if (!readyM) begin
      fill++;
      if (fill == DEPTH) begin
        readyM = 1'b1;
        foreach (memM[k]) memM[k] = '0;
      end
    end else if (req) begin
      if (we) memM[addr] = wdata;
      else    pend.push_back('{cyc + LAT - 1, memM[addr]});
    end
    expV = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      expV  = 1'b1;
      lastD = pend[0].data;
      void'(pend.pop_front());
    end
  endtask

  // drive one cycle of inputs, clock it, then compare against the model
  task automatic applyStimulus(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                               input logic [DATA_W-1:0] d, input logic c);
    req = r; we = w; addr = a; wdata = d; clr = c;
    @(posedge clk);
    #1;
    modelEdge();
    checkOutput("ready", 32'(ready), 32'(readyM));
    checkOutput("rdata_valid", 32'(rdata_valid), 32'(expV));
    checkOutput("rdata", 32'(rdata), 32'(lastD));
  endtask

  task automatic doReset();
    #2;
    rst = 1'b1;
    #1;
    readyM = 1'b0; fill = 0; lastD = '0; expV = 1'b0;
    pend.delete();
    checkOutput("async_ready", 32'(ready), 32'd0);
    checkOutput("async_valid", 32'(rdata_valid), 32'd0);
    checkOutput("async_rdata", 32'(rdata), 32'd0);
    req = 1'b0; clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // counts edges until ready, optionally firing a write that must be dropped
  task automatic waitReady(input string name, input logic blockedWr, output int pulses);
    int edges = 0;
    pulses = 0;
    for (int i = 1; i <= 40; i++) begin
      if (blockedWr && i == 3) applyStimulus(1'b1, 1'b1, 4'd5, 16'hAAAA, 1'b0);
      else                     applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
      if (rdata_valid) pulses++;
      edges = i;
      if (ready) break;
    end
    checkOutput(name, 32'(edges), 32'(DEPTH));
  endtask

  initial begin
    int pulses;
    int first;
    rst = 1'b1; clr = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    cyc = 0; fill = 0; readyM = 1'b0; lastD = '0; expV = 1'b0;
    foreach (memM[k]) memM[k] = '0;

    tbl[0] = '{1'b1, 1'b1, 4'd3,  16'hBEEF, 1'b0, 16'h0000};
    tbl[1] = '{1'b1, 1'b0, 4'd3,  16'h0000, 1'b0, 16'h0000};
    tbl[2] = '{1'b1, 1'b1, 4'd15, 16'h1234, 1'b0, 16'h0000};
    tbl[3] = '{1'b1, 1'b0, 4'd15, 16'h0000, 1'b1, 16'hBEEF};
    tbl[4] = '{1'b1, 1'b0, 4'd0,  16'h0000, 1'b0, 16'hBEEF};
    tbl[5] = '{1'b0, 1'b0, 4'd0,  16'h0000, 1'b1, 16'h1234};
    tbl[6] = '{1'b0, 1'b0, 4'd0,  16'h0000, 1'b1, 16'h0000};
    tbl[7] = '{1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 16'h0000};

    @(negedge clk);
    doReset();
    waitReady("reset_fill_edges", 1'b1, pulses);
    checkOutput("reset_fill_pulses", 32'(pulses), 32'd0);

    // read every word back-to-back; the write to addr 5 during fill must be gone
    pulses = 0; first = -1;
    for (int i = 0; i < DEPTH + LAT; i++) begin
      if (i < DEPTH) applyStimulus(1'b1, 1'b0, ADDR_W'(i), '0, 1'b0);
      else           applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
      if (rdata_valid) begin
        if (first < 0) first = i;
        pulses++;
        checkOutput("cleared_word", 32'(rdata), 32'd0);
      end
    end
    checkOutput("cleared_pulses", 32'(pulses), 32'(DEPTH));
    checkOutput("cleared_first", 32'(first), 32'(LAT - 1));

    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].wdata, 1'b0);
      checkOutput($sformatf("tbl%0d_valid", i), 32'(rdata_valid), 32'(tbl[i].expv));
      checkOutput($sformatf("tbl%0d_rdata", i), 32'(rdata), 32'(tbl[i].expd));
    end

    // clear with two reads in flight: both must vanish
    applyStimulus(1'b1, 1'b0, 4'd1, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd2, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
    checkOutput("clr_ready", 32'(ready), 32'd0);
    checkOutput("clr_valid", 32'(rdata_valid), 32'd0);
    waitReady("clr_fill_edges", 1'b0, pulses);
    checkOutput("clr_fill_pulses", 32'(pulses), 32'd0);
    applyStimulus(1'b1, 1'b0, 4'd3, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("clr_addr3_valid", 32'(rdata_valid), 32'd1);
    checkOutput("clr_addr3_data", 32'(rdata), 32'd0);

    // async reset while a read pulse is on the output
    applyStimulus(1'b1, 1'b1, 4'd7, 16'h5A5A, 1'b0);
    for (int i = 0; i < LAT; i++) applyStimulus(1'b1, 1'b0, 4'd7, '0, 1'b0);
    checkOutput("pre_rst_valid", 32'(rdata_valid), 32'd1);
    checkOutput("pre_rst_data", 32'(rdata), 32'h5A5A);
    doReset();
    waitReady("rst_fill_edges", 1'b0, pulses);

    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 9) < 7, 1'($urandom), ADDR_W'($urandom),
                    DATA_W'($urandom), $urandom_range(0, 59) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/ram_clear_port.md
Name: ram_clear_port

Overview:
- Single-port synchronous RAM with a request/valid interface. It sits directly downstream of read_write_ram and services that block's reads and writes.
- On reset or on a clear pulse, it zero-fills every word with an internal FSM before accepting traffic.
- `ready` tells the upstream sequencer when requests may be issued.
- Reads are fully pipelined, with a fixed, parameterised latency.

Parameters:
- DATA_W, 16, data word width in bits.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words (16 by default).
- READ_LAT, 1, cycles from an accepted read request to `rdata_valid`; legal range 1..4.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous pulse; restarts the zero-fill.
- req  input  1  request strobe, sampled on the rising edge.
- we  input  1  1 = write, 0 = read; qualified by `req`.
- addr  input  ADDR_W  word address.
- wdata  input  DATA_W  write data.
- ready  output  1  1 = zero-fill complete; requests are accepted.
- rdata_valid  output  1  one-cycle pulse per completed read.
- rdata  output  DATA_W  read data; meaningful only while `rdata_valid` = 1.

Behaviour:
- Reset (`rst` = 1, asynchronous):
  - state = INIT, clr_cnt = 0.
  - ready = 0, rdata_valid = 0, rdata = 0.
  - All read-pipeline valid bits = 0.
  - Memory contents are not touched by `rst` itself; the INIT pass clears them.
- States: INIT and RUN.
- INIT:
  - Each rising edge writes 0 to mem[clr_cnt] and increments clr_cnt.
  - On the edge that writes clr_cnt = DEPTH-1, state goes to RUN and `ready` becomes 1 (registered).
  - `ready` therefore rises exactly DEPTH edges after `rst` falls. With the default, that is the 16th edge.
- RUN:
  - `ready` = 1.
  - `clr` = 1 at an edge → INIT, clr_cnt = 0, `ready` = 0 from that edge.
- Request acceptance:
  - A request is accepted only when req = 1, ready = 1 and clr = 0 at the same edge.
  - Any other request is silently dropped: no memory change, no `rdata_valid`.
- Write: an accepted request with we = 1 writes mem[addr] = wdata at that edge. There is no response pulse.
- Read:
  - An accepted request with we = 0 captures mem[addr] into a READ_LAT-deep pipeline.
  - `rdata_valid` = 1 and `rdata` = data exactly READ_LAT edges after acceptance.
  - Throughput is one read per cycle; back-to-back reads produce back-to-back valid pulses, in request order.
- Read-after-write:
  - A read accepted on the edge after a write to the same address returns the new data.
  - A read accepted on the same edge as a write cannot occur (single port); `we` selects the operation.
- `clr` with reads in flight:
  - The pipeline is flushed on the `clr` edge, so no `rdata_valid` pulses occur for those reads.
  - `rdata` holds its last value.
- `rdata` when `rdata_valid` = 0: holds its last valid value (0 after reset).
- `rst` mid-INIT or mid-RUN: immediately returns to the reset values above. The zero-fill restarts from address 0 after `rst` falls.
- `clr` asserted during INIT: clr_cnt restarts at 0 and `ready` stays 0.
- Address arithmetic:
  - clr_cnt is ADDR_W bits wide; terminal count is DEPTH-1, with no wrap into RUN early.
  - `addr` is always in range because DEPTH = 2**ADDR_W.

Test Plan:
- Reset release: pulse `rst`, then hold req = 0 → ready = 0 for 15 edges and ready = 1 on the 16th. rdata_valid stays 0 throughout.
- Cleared contents: after ready = 1, read addresses 0..15 back-to-back → 16 consecutive rdata_valid pulses, each with rdata = 0x0000, with the first pulse READ_LAT edges after the first request.
- Write then read: write 0xBEEF to addr 3, then read addr 3 on the next edge → one pulse with rdata = 0xBEEF. Also write 0x1234 to addr 15 and read it → 0x1234.
- Blocked request: issue a write of 0xAAAA to addr 5 while ready = 0 (during INIT). After ready = 1, read addr 5 → 0x0000.
- `clr` behaviour: with READ_LAT = 3, issue 2 reads, then assert `clr` on the next edge → no rdata_valid pulses and ready = 0 for 16 edges. Afterwards, a read of addr 3 (previously 0xBEEF) → 0x0000.
- Asynchronous reset: assert `rst` between clock edges mid-RUN with a read in flight → ready and rdata_valid drop immediately without a clock edge, and the 16-edge zero-fill repeats after release.
